// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared definitions for the programmable clock divider
//
// Purpose : channel FSM state encoding and the default counter width.
// Ports   : none (package).

package clk_div_pkg;

    localparam int DEF_CNT_W = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } chan_state_t;

endpackage

// File: rtl/clk_div_chan.sv
// rtl/clk_div_chan.sv - one divider channel: counter, FSM, pending ratio and apply logic
//
// Purpose : divides clk by the active ratio R (high ceil(R/2) cycles, low the rest).
//           A newly loaded ratio sits in a pending register. It is applied at the
//           period boundary when the channel runs, or on the next edge when it is idle.
// Ports   : clk       - system clock
//           rst       - asynchronous active-high reset
//           en        - global run enable
//           load      - capture ratio_in into the pending register
//           ratio_in  - new ratio for this channel
//           clk_out   - divided clock (registered)
//           tick      - one-cycle pulse on each clk_out rising edge
//           pending   - a loaded ratio has not been applied yet

module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int               CNT_W     = DEF_CNT_W,
    parameter logic [CNT_W-1:0] DEF_RATIO = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [CNT_W-1:0] ratio_in,
    output logic             clk_out,
    output logic             tick,
    output logic             pending
);

    localparam logic [CNT_W-1:0] ONE = 1;
    localparam logic [CNT_W-1:0] TWO = 2;

    chan_state_t      state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] ratio;
    logic [CNT_W-1:0] pend_ratio;
    logic             pend_flag;

    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] high_len;
    logic [CNT_W-1:0] next_ratio;
    logic             wrap;
    logic             next_ok;

    always_comb begin
        cnt_inc    = cnt + ONE;
        // ceil(R/2): odd ratios get the longer high phase
        high_len   = ratio - (ratio >> 1);
        // Comparing against R-1 keeps the counter inside [0, R-1] even at R = 2**CNT_W-1
        wrap       = (cnt == (ratio - ONE));
        // Ratio in force after this edge if the pending value gets applied on it
        next_ratio = pend_flag ? pend_ratio : ratio;
        next_ok    = (next_ratio >= TWO);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            ratio      <= DEF_RATIO;
            pend_ratio <= '0;
            pend_flag  <= 1'b0;
            clk_out    <= 1'b0;
            tick       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pend_flag) begin
                        ratio     <= pend_ratio;
                        pend_flag <= 1'b0;
                    end
                    cnt <= '0;
                    if (en && next_ok) begin
                        state   <= ST_RUN;
                        clk_out <= 1'b1;
                        tick    <= 1'b1;
                    end else begin
                        clk_out <= 1'b0;
                        tick    <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (!en) begin
                        // Any pending ratio is kept and applied from IDLE on the next edge
                        state   <= ST_IDLE;
                        cnt     <= '0;
                        clk_out <= 1'b0;
                        tick    <= 1'b0;
                    end else if (wrap) begin
                        if (pend_flag) begin
                            ratio     <= pend_ratio;
                            pend_flag <= 1'b0;
                        end
                        cnt <= '0;
                        if (next_ok) begin
                            clk_out <= 1'b1;
                            tick    <= 1'b1;
                        end else begin
                            // Ratio 0 or 1 switches the channel off at the boundary
                            state   <= ST_IDLE;
                            clk_out <= 1'b0;
                            tick    <= 1'b0;
                        end
                    end else begin
                        cnt     <= cnt_inc;
                        clk_out <= (cnt_inc < high_len);
                        tick    <= 1'b0;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    cnt     <= '0;
                    clk_out <= 1'b0;
                    tick    <= 1'b0;
                end
            endcase

            // Placed last so a load on an apply edge re-arms the flag with the new value;
            // the apply on that edge still uses the previously pending ratio.
            if (load) begin
                pend_ratio <= ratio_in;
                pend_flag  <= 1'b1;
            end
        end
    end

    assign pending = pend_flag;

endmodule

// File: rtl/clk_div_prog.sv
// rtl/clk_div_prog.sv - multi-channel programmable clock divider top level
//
// Purpose : CHANNELS independent dividers with runtime-loadable ratios. Defaults give /2 /4 /8.
// Ports   : clk       - system clock
//           rst       - asynchronous active-high reset
//           en        - global run enable, common to all channels
//           div_ratio - packed new ratios, channel i at [i*CNT_W +: CNT_W]
//           load      - one-cycle strobe capturing div_ratio into every pending register
//           clk_out   - divided clocks (registered)
//           tick      - one-cycle pulses coincident with clk_out rising edges
//           upd_busy  - some channel still holds an unapplied ratio

module clk_div_prog
    import clk_div_pkg::*;
#(
    parameter int                        CHANNELS   = 3,
    parameter int                        CNT_W      = DEF_CNT_W,
    parameter logic [CHANNELS*CNT_W-1:0] DEF_RATIOS = {8'd8, 8'd4, 8'd2}
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [CHANNELS*CNT_W-1:0] div_ratio,
    input  logic                      load,
    output logic [CHANNELS-1:0]       clk_out,
    output logic [CHANNELS-1:0]       tick,
    output logic                      upd_busy
);

    logic [CHANNELS-1:0] pending;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        clk_div_chan #(
            .CNT_W     (CNT_W),
            .DEF_RATIO (DEF_RATIOS[g*CNT_W +: CNT_W])
        ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .en       (en),
            .load     (load),
            .ratio_in (div_ratio[g*CNT_W +: CNT_W]),
            .clk_out  (clk_out[g]),
            .tick     (tick[g]),
            .pending  (pending[g])
        );
    end

    // The load term makes busy rise on the load edge itself; the pending flags keep it
    // high through the last apply edge, so it falls on the edge after that.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            upd_busy <= 1'b0;
        end else begin
            upd_busy <= load | (|pending);
        end
    end

endmodule

// File: tb/tb_clk_div_prog.sv
// tb/tb_clk_div_prog.sv - self-checking bench for clk_div_prog

module tb_clk_div_prog;

    localparam int CH = 3;
    localparam int W  = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            en;
    logic            load;
    logic [CH*W-1:0] div_ratio;
    logic [CH-1:0]   clk_out;
    logic [CH-1:0]   tick;
    logic            upd_busy;

    int n_pass  = 0;
    int n_total = 0;

    clk_div_prog dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .div_ratio (div_ratio),
        .load      (load),
        .clk_out   (clk_out),
        .tick      (tick),
        .upd_busy  (upd_busy)
    );

    initial begin
        #5;
        forever #10 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Model: each running channel remembers the edge index its current period started on;
    // its position in the period is the distance from that edge.
    int          cyc = 0;
    int          m_r[CH];
    int          m_start[CH];
    int          m_pend[CH];
    bit          m_pv[CH];
    bit          m_run[CH];
    logic [CH-1:0] e_clk  = '0;
    logic [CH-1:0] e_tick = '0;
    logic          e_busy = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_r[0] = 2; m_r[1] = 4; m_r[2] = 8;
            for (int i = 0; i < CH; i++) begin
                m_run[i] = 0; m_pv[i] = 0; m_pend[i] = 0; m_start[i] = 0;
            end
            e_clk = '0; e_tick = '0; e_busy = 1'b0;
        end else begin
            bit any;
            any = 0;
            cyc++;
            for (int i = 0; i < CH; i++) any |= m_pv[i];
            for (int i = 0; i < CH; i++) begin
                if (!m_run[i]) begin
                    if (m_pv[i]) begin m_r[i] = m_pend[i]; m_pv[i] = 0; end
                    if (en && m_r[i] >= 2) begin m_run[i] = 1; m_start[i] = cyc; end
                end else if (!en) begin
                    m_run[i] = 0;
                end else if (cyc - m_start[i] == m_r[i]) begin
                    if (m_pv[i]) begin m_r[i] = m_pend[i]; m_pv[i] = 0; end
                    if (m_r[i] < 2) m_run[i] = 0;
                    else m_start[i] = cyc;
                end
            end
            if (load) begin
                for (int i = 0; i < CH; i++) begin
                    m_pend[i] = int'(div_ratio[i*W +: W]);
                    m_pv[i]   = 1;
                end
            end
            e_busy = load | any;
            for (int i = 0; i < CH; i++) begin
                int pos;
                pos       = cyc - m_start[i];
                e_clk[i]  = m_run[i] && (pos < (m_r[i] + 1) / 2);
                e_tick[i] = m_run[i] && (pos == 0);
            end
        end
    end

    always @(negedge clk) begin
        check("cyc_clk_out", {29'd0, clk_out}, {29'd0, e_clk});
        check("cyc_tick", {29'd0, tick}, {29'd0, e_tick});
        check("cyc_upd_busy", {31'd0, upd_busy}, {31'd0, e_busy});
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_load(input logic [CH*W-1:0] v);
        div_ratio = v;
        load      = 1'b1;
        @(negedge clk);
        load      = 1'b0;
    endtask

    task automatic wait_tick(input int ch, input int limit, output int n);
        n = 0;
        while (tick[ch] !== 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        int n, h, l, acc;
        rst = 1'b1; en = 1'b0; load = 1'b0; div_ratio = '0;
        #1;
        check("rst_clk_out", {29'd0, clk_out}, 32'd0);
        check("rst_tick", {29'd0, tick}, 32'd0);
        check("rst_busy", {31'd0, upd_busy}, 32'd0);
        #49 rst = 1'b0;

        // Defaults: all channels start together
        @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        check("t1_first_clk", {29'd0, clk_out}, 32'h7);
        check("t1_first_tick", {29'd0, tick}, 32'h7);
        @(negedge clk);
        check("t1_second_clk", {29'd0, clk_out}, 32'h6);
        check("t1_second_tick", {29'd0, tick}, 32'h0);
        cycles(14);

        // ch0 ratio 5
        do_load({8'd8, 8'd4, 8'd5});
        cycles(10);
        h = 0; n = 0;
        for (int k = 0; k < 20; k++) begin
            h += int'(clk_out[0]);
            n += int'(tick[0]);
            @(negedge clk);
        end
        check("t2_ch0_ticks", n, 4);
        check("t2_ch0_high", h, 12);

        // ch2 8 -> 3 loaded at cnt=2
        wait_tick(2, 20, n);
        check("t3_sync", {31'd0, tick[2]}, 32'd1);
        cycles(2);
        check("t3_busy_before", {31'd0, upd_busy}, 32'd0);
        do_load({8'd3, 8'd4, 8'd5});
        check("t3_busy_load", {31'd0, upd_busy}, 32'd1);
        wait_tick(2, 20, n);
        check("t3_edges_to_wrap", n, 5);
        check("t3_busy_apply", {31'd0, upd_busy}, 32'd1);
        @(negedge clk);
        check("t3_busy_clear", {31'd0, upd_busy}, 32'd0);
        h = 0; n = 0;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            h += int'(clk_out[2]);
            n += int'(tick[2]);
        end
        check("t3_ch2_ticks", n, 3);
        check("t3_ch2_high", h, 6);

        // ch1 off, then back on
        do_load({8'd3, 8'd0, 8'd5});
        cycles(8);
        acc = 0;
        for (int k = 0; k < 4; k++) begin
            acc += int'(clk_out[1]) + int'(tick[1]);
            @(negedge clk);
        end
        check("t4_ch1_off", acc, 0);
        do_load({8'd3, 8'd4, 8'd5});
        check("t4_ch1_still_idle", {31'd0, clk_out[1]}, 32'd0);
        @(negedge clk);
        check("t4_ch1_restart_tick", {31'd0, tick[1]}, 32'd1);
        check("t4_ch1_restart_clk", {31'd0, clk_out[1]}, 32'd1);

        // en drop and in-phase restart
        cycles(3);
        en = 1'b0;
        @(negedge clk);
        check("t5_stop_clk", {29'd0, clk_out}, 32'd0);
        check("t5_stop_tick", {29'd0, tick}, 32'd0);
        cycles(2);
        en = 1'b1;
        @(negedge clk);
        check("t5_restart_tick", {29'd0, tick}, 32'h7);
        check("t5_restart_clk", {29'd0, clk_out}, 32'h7);

        // Asynchronous reset mid-run
        cycles(5);
        @(posedge clk);
        #5 rst = 1'b1;
        #1;
        check("t6_rst_clk", {29'd0, clk_out}, 32'd0);
        check("t6_rst_tick", {29'd0, tick}, 32'd0);
        check("t6_rst_busy", {31'd0, upd_busy}, 32'd0);
        @(negedge clk);
        #3 rst = 1'b0;
        @(negedge clk);
        check("t6_default_first", {29'd0, clk_out}, 32'h7);
        @(negedge clk);
        check("t6_default_second", {29'd0, clk_out}, 32'h6);

        do_load({8'd8, 8'd4, 8'd255});
        n = 0;
        while (upd_busy === 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("t6_busy_settle", {31'd0, upd_busy}, 32'd0);
        wait_tick(0, 300, n);
        check("t6_ch0_period_start", {31'd0, tick[0]}, 32'd1);
        h = 0;
        while (clk_out[0] === 1'b1 && h < 300) begin
            h++;
            @(negedge clk);
        end
        l = 0;
        while (tick[0] !== 1'b1 && l < 300) begin
            l++;
            @(negedge clk);
        end
        check("t6_ch0_high", h, 128);
        check("t6_ch0_low", l, 127);
        check("t6_ch0_wrap_clk", {31'd0, clk_out[0]}, 32'd1);
        cycles(3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
